small_decimator: RTL and testbench

- Integrate-and-dump decimator that sits directly downstream of the second-order small low-pass filter.
- Consumes one filtered sample per enabled clock and emits one sample per block of 2^DEC_SHIFT input samples, with a one-cycle valid strobe.
- Together with the low-pass filter it forms a fixed-ratio rate-reduction chain.
- Output is either the rounded block average or the last sample of the block (plain downsample).

---
 rtl/small_decimator.sv | 89 ++++++++
 tb/tb_small_decimator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/small_decimator.sv
// Integrate-and-dump decimator: emits the rounded mean (or the last sample) of
// every block of 2^DEC_SHIFT enabled input samples, with a one-cycle valid strobe.
module small_decimator #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEC_SHIFT = 4,
  parameter int unsigned AVERAGE   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             align,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             outValid
);

  localparam int unsigned N  = 1 << DEC_SHIFT;
  localparam int unsigned AW = WIDTH + DEC_SHIFT;
  localparam int unsigned SW = AW + 1;

  localparam logic [DEC_SHIFT-1:0] LAST_CNT = DEC_SHIFT'(N - 1);
  localparam logic [DEC_SHIFT-1:0] ONE_CNT  = DEC_SHIFT'(1);
  localparam logic signed [SW-1:0] ROUND    = SW'(N / 2);

  logic [DEC_SHIFT-1:0]    cnt_q, cnt_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;

  logic signed [WIDTH-1:0] din_s;
  logic signed [AW-1:0]    din_ext;
  logic signed [SW-1:0]    sum_rnd;
  logic signed [SW-1:0]    sum_shr;
  logic signed [WIDTH-1:0] mean;

  assign din_s   = dataIn;
  assign din_ext = AW'(din_s);

  // Block total plus half an LSB of the quotient, floored by the arithmetic shift.
  assign sum_rnd = SW'(acc_q) + SW'(din_s) + ROUND;
  assign sum_shr = sum_rnd >>> DEC_SHIFT;
  assign mean    = WIDTH'(sum_shr);

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (align) begin
      if (en) begin
        acc_d = din_ext;
        cnt_d = ONE_CNT;
      end else begin
        acc_d = '0;
        cnt_d = '0;
      end
    end else if (en) begin
      if (cnt_q == '0) begin
        acc_d = din_ext;
        cnt_d = ONE_CNT;
      end else if (cnt_q == LAST_CNT) begin
        cnt_d   = '0;
        valid_d = 1'b1;
        data_d  = (AVERAGE != 0) ? mean : din_s;
      end else begin
        acc_d = acc_q + din_ext;
        cnt_d = cnt_q + ONE_CNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dataOut  = data_q;
  assign outValid = valid_q;

endmodule

// File: tb/tb_small_decimator.sv
// Bench for small_decimator: three instances (N=16 mean, N=4 mean, N=4 downsample)
// checked every cycle against a block-sum model, plus hand-computed directed checks.
module tb_small_decimator;

  logic        clk = 1'b0;
  logic        rst, en, align;
  logic [15:0] din;
  logic [15:0] d4, d2, d2n;
  logic        v4, v2, v2n;

  int checks = 0;
  int errors = 0;
  bit started = 0;
  int pulses4 = 0, pulses2 = 0, pulses2n = 0;

  always #5 clk = ~clk;

  small_decimator #(.WIDTH(16), .DEC_SHIFT(4), .AVERAGE(1)) dut4 (
    .clk(clk), .rst(rst), .en(en), .align(align), .dataIn(din),
    .dataOut(d4), .outValid(v4));
  small_decimator #(.WIDTH(16), .DEC_SHIFT(2), .AVERAGE(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .align(align), .dataIn(din),
    .dataOut(d2), .outValid(v2));
  small_decimator #(.WIDTH(16), .DEC_SHIFT(2), .AVERAGE(0)) dut2n (
    .clk(clk), .rst(rst), .en(en), .align(align), .dataIn(din),
    .dataOut(d2n), .outValid(v2n));

  // Model: per instance, number of samples and their sum in the current block.
  int          blk_n   [3] = '{16, 4, 4};
  bit          blk_avg [3] = '{1'b1, 1'b1, 1'b0};
  int          m_cnt   [3];
  longint      m_sum   [3];
  logic        m_valid [3];
  logic [15:0] m_out   [3];

  function automatic longint floor_mean_rounded(longint sum, int n);
    longint num, den, q;
    num = 2 * sum + n;          // (sum/n + 1/2) expressed over 2n
    den = 2 * n;
    q   = num / den;
    if (num < 0 && (num % den) != 0) q = q - 1;
    return q;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      automatic int          c = m_cnt[k];
      automatic longint      s = m_sum[k];
      automatic logic        v = 1'b0;
      automatic logic [15:0] o = m_out[k];
      automatic longint      x = longint'($signed(din));
      if (rst) begin
        c = 0; s = 0; o = '0;
      end else if (align) begin
        if (en) begin c = 1; s = x; end
        else begin c = 0; s = 0; end
      end else if (en) begin
        c = c + 1;
        s = s + x;
        if (c == blk_n[k]) begin
          v = 1'b1;
          o = blk_avg[k] ? 16'(floor_mean_rounded(s, blk_n[k])) : din;
          c = 0; s = 0;
        end
      end
      m_cnt[k]   <= c;
      m_sum[k]   <= s;
      m_valid[k] <= v;
      m_out[k]   <= o;
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Every-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("v4",   longint'(v4),  longint'(m_valid[0]));
      check("d4",   longint'($signed(d4)),  longint'($signed(m_out[0])));
      check("v2",   longint'(v2),  longint'(m_valid[1]));
      check("d2",   longint'($signed(d2)),  longint'($signed(m_out[1])));
      check("v2n",  longint'(v2n), longint'(m_valid[2]));
      check("d2n",  longint'($signed(d2n)), longint'($signed(m_out[2])));
      if (v4)  pulses4++;
      if (v2)  pulses2++;
      if (v2n) pulses2n++;
    end
  end

  // Drive one clock of inputs; returns #1 after the following falling edge.
  task automatic step(input bit r, input bit e, input bit a, input int d);
    rst = r; en = e; align = a; din = 16'(d);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic block2(input string name, input int a, input int b, input int c,
                        input int d, input int want);
    step(0, 1, 0, a); step(0, 1, 0, b); step(0, 1, 0, c);
    check({name, "_nv"}, longint'(v2), 0);
    step(0, 1, 0, d);
    check({name, "_v"}, longint'(v2), 1);
    check(name, longint'($signed(d2)), longint'(want));
  endtask

  initial begin
    int p0, p1;
    rst = 1'b1; en = 1'b0; align = 1'b0; din = '0;
    @(posedge clk);
    do_reset();
    started = 1;
    check("rst_d4", longint'(d4), 0);
    check("rst_v4", longint'(v4), 0);

    // Constant input: N=16 pulses after 16 samples, then every 16.
    p0 = pulses4;
    for (int i = 1; i <= 32; i++) begin
      step(0, 1, 0, 1000);
      if (i == 15) check("c_nv15", longint'(v4), 0);
      if (i == 16) check("c_v16",  longint'(v4), 1);
    end
    check("c_cnt", longint'(pulses4 - p0), 2);
    check("c_val", longint'($signed(d4)), 1000);

    // Rounding on N=4 blocks.
    do_reset();
    block2("r_110",  1, 1, 0, 0, 1);
    block2("r_m1m1", -1, -1, 0, 0, 0);
    block2("r_111",  1, 1, 1, 0, 1);
    block2("r_m15",  -2, -2, -1, -1, -1);
    block2("r_p15",  2, 2, 1, 1, 2);
    block2("r_max",  32767, 32767, 32767, 32767, 32767);
    block2("r_min",  -32768, -32768, -32768, -32768, -32768);

    // en gating with junk on disabled cycles.
    do_reset();
    p0 = pulses2;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(0, 1, 0, 100);
      else            step(0, 0, 0, 9999);
    end
    check("g_cnt", longint'(pulses2 - p0), 2);
    check("g_val", longint'($signed(d2)), 100);

    // Plain downsample of a ramp.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, i);
      if (i == 3) begin check("ds_v3", longint'(v2n), 1); check("ds_3", longint'(d2n), 3); end
      if (i == 7) begin check("ds_v7", longint'(v2n), 1); check("ds_7", longint'(d2n), 7); end
    end

    // Align mid-block, then reset mid-block.
    do_reset();
    step(0, 1, 0, 8); step(0, 1, 0, 8);
    step(0, 1, 1, 8);
    check("al_nv", longint'(v2), 0);
    step(0, 1, 0, 8); step(0, 1, 0, 8);
    check("al_nv3", longint'(v2), 0);
    step(0, 1, 0, 8);
    check("al_v", longint'(v2), 1);
    check("al_d", longint'($signed(d2)), 8);
    step(0, 1, 0, 8); step(0, 1, 0, 8); step(0, 1, 0, 8);
    step(1, 1, 0, 8);
    check("rs_d", longint'(d2), 0);
    check("rs_v", longint'(v2), 0);
    p1 = pulses2;
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8);
    check("rs_cnt", longint'(pulses2 - p1), 1);
    check("rs_val", longint'($signed(d2)), 8);
    step(0, 1, 0, 8);
    step(0, 0, 1, 5);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8);
    check("al0_nv", longint'(v2), 0);
    step(0, 1, 0, 8);
    check("al0_v", longint'(v2), 1);

    // Random full-scale input with sparse gaps and aligns.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0),
           int'($urandom_range(0, 65535)) - 32768);
    end

    started = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
